soma_pipe: RTL and testbench
============================

# soma_pipe

Pipelined, parametrised successor to the single-neuron soma datapath. It sweeps a configurable neuron range once per `start`, reading each neuron's membrane state from internal RAM and its dendrite sum from the SD stage. It applies saturating integrate, leak, threshold, selectable reset and a per-neuron refractory counter, then writes the state back. Fired neuron addresses go out through a credit-controlled spike FIFO with a valid/ready handshake. It sits between the SD (dendrite) stage and the spike-out/router stage of a node.

## Interface
Parameters:
- `NNW`, 12, neuron address width; RAM depth is 2^NNW.
- `VW`, 20, membrane potential width, unsigned.
- `RW`, 4, refractory counter width.
- `FD`, 4, spike FIFO depth (power of 2, ≥2).

Ports (name, direction, width, meaning):
- `clk_soma` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a sweep; ignored while `busy`.
- `nrn_base` in NNW: first neuron address of the sweep.
- `nrn_count` in NNW+1: number of neurons in the sweep (0..2^NNW).
- `cfg_vth` in VW: fire threshold.
- `cfg_leak` in VW: leak subtracted per sweep.
- `cfg_reset_mode` in 2: 00 reset to zero, 01 subtract threshold, 10 no reset, 11 behaves as 00.
- `cfg_refrac` in RW: refractory sweeps after a fire.
- `sd_re` out 1: dendrite read strobe.
- `sd_addr` out NNW: dendrite read address.
- `sd_vm` in VW: dendrite sum, valid the cycle after `sd_re`.
- `spk_vld` out 1: spike FIFO head valid.
- `spk_addr` out NNW: address of the fired neuron.
- `spk_rdy` in 1: downstream accept.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at end of sweep.
- `cfg_we` in 1: host write of a neuron's state.
- `cfg_re` in 1: host read of a neuron's state.
- `cfg_addr` in NNW: host access address.
- `cfg_wdata` in VW: host write data.
- `cfg_rdata` out VW: stored vm, valid the cycle after `cfg_re`.

## Operation
- FSM states:
  - IDLE → RUN on `start` when `nrn_count`≠0.
  - IDLE → DONE on `start` when `nrn_count`=0.
  - RUN → DRAIN after the last issue.
  - DRAIN → DONE when stage 1 is empty.
  - DONE → IDLE unconditionally; `done`=1 for that one cycle.
- `busy`=1 in RUN, DRAIN and DONE.
- Issue (stage 0):
  - Neuron index i counts 0..nrn_count-1.
  - Address = (nrn_base+i) mod 2^NNW, so the range wraps past 2^NNW-1 to 0.
  - A neuron issues only when fifo_count + inflight < FD.
  - On issue: `sd_re`=1, `sd_addr`=address, and the RAM read of {refrac_cnt, vm} fires in the same cycle.
- Update (stage 1), performed by the `soma_update` function:
  - If refrac_cnt≠0: vm unchanged, cnt−1, no fire.
  - Otherwise sum = vm+sd_vm, computed on VW+1 bits and saturated to 2^VW−1.
  - fire = sum ≥ cfg_vth.
  - On fire: vm per `cfg_reset_mode` (0, sum−vth, or sum); cnt = cfg_refrac; address pushed into the FIFO.
  - No fire: vm = sum−leak if sum>leak, else 0; cnt = 0.
  - Writeback of {cnt, vm} happens in the same cycle.
- There is no read-after-write hazard, because addresses within a sweep are distinct.
- Host port:
  - Active only in IDLE; `cfg_we`/`cfg_re` while `busy` are ignored (no write, rdata unchanged).
  - Writes store vm = cfg_wdata and cnt = 0.
  - Simultaneous `cfg_we` and `cfg_re` are allowed; the read returns old data.
- Spike FIFO:
  - Pops on `spk_vld && spk_rdy`.
  - Overflow is impossible by the credit rule.
  - The FIFO may still hold spikes after `done`; downstream drains it independently.
- Reset:
  - Asynchronous reset clears FSM, index, inflight, FIFO and pipeline.
  - Outputs after reset: `busy`, `done`, `spk_vld`, `sd_re`=0; `sd_addr`, `spk_addr`, `cfg_rdata`=0.
  - RAM contents are not reset.

## Timing
- Issue at cycle t: RAM data and `sd_vm` arrive at t+1, writeback at t+1, FIFO push at end of t+1, earliest `spk_vld` at t+2.
- Throughput: 1 neuron/cycle while FIFO credits allow.
- With `spk_rdy`=0 held, issue halts once FD spikes are outstanding and resumes the cycle after a pop.
- Sweep with no backpressure: `start` at cycle 0, issues at cycles 1..N, `done` at cycle N+2.
- `nrn_count`=0: `done` at cycle 1, no `sd_re`.
- A `start` coincident with `done` is ignored.
- A reset asserted mid-sweep leaves partially written RAM state, which is accepted behaviour.

## Structure
- Shared package `soma_pkg`: reset-mode encodings, the FSM state enum, and the `{cnt, vm}` state-word typedef of width RW+VW.
- Sub-module `soma_update`: the combinational stage-1 arithmetic, to allow reuse by future multi-lane variants.
- State RAM: the existing `dp_ram` at width RW+VW.
- FIFO: inline in this block.

## Test plan
- Neuron 5 preloaded vm=90, vth=100, leak=3, sd_vm=15, mode 01, sweep base 5 count 1 → spike addr 5 at cycle 3; stored vm=5, cnt=cfg_refrac.
- cfg_refrac=2, sd_vm=200 every sweep → fires in sweep 1, silent in sweeps 2–3, fires again in sweep 4; vm unchanged during the refractory sweeps.
- vm=2^VW−10, sd_vm=50, vth=2^VW−1 → sum saturates; fires; mode 10 keeps vm=2^VW−1.
- Base 4094, count 4, NNW=12 → `sd_addr` sequence 4094, 4095, 0, 1; `done` 2 cycles after the last issue.
- All 16 neurons firing, `spk_rdy`=0 for 20 cycles, FD=4 → exactly 4 issues before the stall; after release all 16 addresses are emitted in order, with none lost or duplicated.
- `rst_n` pulsed mid-sweep → `busy`, `spk_vld` and `done` are 0 immediately; a new `start` then runs a clean sweep.

Source files
------------

// File: rtl/soma_pkg.sv
// ============================================================================
// soma_pkg : shared types and encodings for the soma sweep pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

package soma_pkg;

  localparam int c_vw = 20;
  localparam int c_rw = 4;

  localparam logic [1:0] c_rst_zero = 2'b00;
  localparam logic [1:0] c_rst_sub  = 2'b01;
  localparam logic [1:0] c_rst_none = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } soma_state_e;

  typedef struct packed {
    logic [c_rw-1:0] cnt;
    logic [c_vw-1:0] vm;
  } state_word_t;

endpackage

`default_nettype wire

// File: rtl/dp_ram.sv
// ============================================================================
// dp_ram : simple dual-port RAM, one write port, one registered read-first port
// Rev 1.0
// ============================================================================
`default_nettype none

module dp_ram #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/soma_update.sv
// ============================================================================
// soma_update : combinational integrate / leak / threshold / reset of one neuron
// Rev 1.0
// ============================================================================
`default_nettype none

module soma_update
  import soma_pkg::*;
#(
  parameter int VW = 20,
  parameter int RW = 4
) (
  input  logic [RW-1:0] cur_cnt,
  input  logic [VW-1:0] cur_vm,
  input  logic [VW-1:0] sd_vm,
  input  logic [VW-1:0] vth,
  input  logic [VW-1:0] leak,
  input  logic [1:0]    reset_mode,
  input  logic [RW-1:0] refrac,
  output logic [RW-1:0] nxt_cnt,
  output logic [VW-1:0] nxt_vm,
  output logic          fire
);

  localparam logic [RW-1:0] c_cnt_one = RW'(1);

  logic [VW:0]   sum_wide;
  logic [VW-1:0] sum;

  always_comb begin
    sum_wide = {1'b0, cur_vm} + {1'b0, sd_vm};
    sum      = sum_wide[VW] ? '1 : sum_wide[VW-1:0];
    nxt_cnt  = cur_cnt;
    nxt_vm   = cur_vm;
    fire     = 1'b0;
    if (cur_cnt != '0) begin
      nxt_cnt = cur_cnt - c_cnt_one;
    end else if (sum >= vth) begin
      fire    = 1'b1;
      nxt_cnt = refrac;
      case (reset_mode)
        c_rst_zero: nxt_vm = '0;
        c_rst_sub:  nxt_vm = sum - vth;
        c_rst_none: nxt_vm = sum;
        default:    nxt_vm = '0;
      endcase
    end else begin
      nxt_cnt = '0;
      nxt_vm  = (sum > leak) ? (sum - leak) : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/soma_pipe.sv
// ============================================================================
// soma_pipe : two-stage neuron sweep with state RAM and credit-gated spike FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module soma_pipe
  import soma_pkg::*;
#(
  parameter int NNW = 12,
  parameter int VW  = 20,
  parameter int RW  = 4,
  parameter int FD  = 4
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           start,
  input  logic [NNW-1:0] nrn_base,
  input  logic [NNW:0]   nrn_count,
  input  logic [VW-1:0]  cfg_vth,
  input  logic [VW-1:0]  cfg_leak,
  input  logic [1:0]     cfg_reset_mode,
  input  logic [RW-1:0]  cfg_refrac,
  output logic           sd_re,
  output logic [NNW-1:0] sd_addr,
  input  logic [VW-1:0]  sd_vm,
  output logic           spk_vld,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_rdy,
  output logic           busy,
  output logic           done,
  input  logic           cfg_we,
  input  logic           cfg_re,
  input  logic [NNW-1:0] cfg_addr,
  input  logic [VW-1:0]  cfg_wdata,
  output logic [VW-1:0]  cfg_rdata
);

  localparam int FAW = $clog2(FD);
  localparam logic [NNW:0] c_idx_one = (NNW+1)'(1);

  // The shared state-word typedef is fixed at the package widths.
  if ((VW != c_vw) || (RW != c_rw)) begin : g_width_check
    $error("soma_pipe: VW/RW must match soma_pkg state word widths");
  end

  soma_state_e    state_q, state_d;
  logic [NNW:0]   idx_q, idx_d, count_q, count_d;
  logic [NNW-1:0] base_q, base_d;
  logic           s1_vld_q, s1_vld_d;
  logic [NNW-1:0] s1_addr_q, s1_addr_d;
  logic           host_rd_q, host_rd_d;
  logic [VW-1:0]  rdata_hold_q, rdata_hold_d;
  logic [NNW-1:0] fifo_mem_q [FD];
  logic [NNW-1:0] fifo_mem_d [FD];
  logic [FAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FAW:0]   fifo_cnt_q, fifo_cnt_d;

  logic           idle, issue, credit_ok, push, pop;
  logic [FAW+1:0] occupancy;
  logic [NNW-1:0] issue_addr;
  logic           ram_we, ram_re;
  logic [NNW-1:0] ram_waddr, ram_raddr;
  state_word_t    ram_rdata, ram_wdata;
  logic [RW-1:0]  upd_cnt;
  logic [VW-1:0]  upd_vm;
  logic           upd_fire;

  assign idle       = (state_q == ST_IDLE);
  assign busy       = ~idle;
  // A neuron in stage 1 may still push, so it holds a FIFO credit.
  assign occupancy  = (FAW+2)'(fifo_cnt_q) + (FAW+2)'(s1_vld_q);
  assign credit_ok  = occupancy < (FAW+2)'(FD);
  assign issue_addr = base_q + idx_q[NNW-1:0];
  assign sd_re      = issue;
  assign sd_addr    = issue ? issue_addr : '0;
  assign spk_vld    = (fifo_cnt_q != '0);
  assign spk_addr   = fifo_mem_q[rd_ptr_q];
  assign cfg_rdata  = rdata_hold_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    count_d = count_q;
    issue   = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = nrn_base;
          count_d = nrn_count;
          idx_d   = '0;
          state_d = (nrn_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          idx_d = idx_q + c_idx_one;
          if (idx_d == count_q) state_d = ST_DRAIN;
        end
      end
      // The last neuron writes back during this cycle, emptying stage 1.
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram_re    = issue | (idle & cfg_re);
    ram_raddr = idle ? cfg_addr : issue_addr;
    ram_we    = s1_vld_q | (idle & cfg_we);
    ram_waddr = s1_vld_q ? s1_addr_q : cfg_addr;
    ram_wdata = s1_vld_q ? {upd_cnt, upd_vm} : {{RW{1'b0}}, cfg_wdata};
  end

  always_comb begin
    s1_vld_d     = issue;
    s1_addr_d    = issue_addr;
    host_rd_d    = idle & cfg_re;
    rdata_hold_d = host_rd_q ? ram_rdata.vm : rdata_hold_q;
    push         = s1_vld_q & upd_fire;
    pop          = spk_vld & spk_rdy;
    fifo_mem_d   = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = s1_addr_q;
    wr_ptr_d     = wr_ptr_q + FAW'(push);
    rd_ptr_d     = rd_ptr_q + FAW'(pop);
    fifo_cnt_d   = fifo_cnt_q + (FAW+1)'(push) - (FAW+1)'(pop);
  end

  soma_update #(.VW(VW), .RW(RW)) u_update (
    .cur_cnt    (ram_rdata.cnt),
    .cur_vm     (ram_rdata.vm),
    .sd_vm      (sd_vm),
    .vth        (cfg_vth),
    .leak       (cfg_leak),
    .reset_mode (cfg_reset_mode),
    .refrac     (cfg_refrac),
    .nxt_cnt    (upd_cnt),
    .nxt_vm     (upd_vm),
    .fire       (upd_fire)
  );

  dp_ram #(.AW(NNW), .DW(RW+VW)) u_state_ram (
    .clk   (clk_soma),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      base_q       <= '0;
      s1_vld_q     <= 1'b0;
      s1_addr_q    <= '0;
      host_rd_q    <= 1'b0;
      rdata_hold_q <= '0;
      fifo_mem_q   <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      base_q       <= base_d;
      s1_vld_q     <= s1_vld_d;
      s1_addr_q    <= s1_addr_d;
      host_rd_q    <= host_rd_d;
      rdata_hold_q <= rdata_hold_d;
      fifo_mem_q   <= fifo_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_soma_pipe.sv
// ============================================================================
// tb_soma_pipe : directed self-checking bench for soma_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_soma_pipe;

  localparam int NNW = 12;
  localparam int VW  = 20;
  localparam int RW  = 4;
  localparam int FD  = 4;

  logic           clk_soma;
  logic           rst_n;
  logic           start;
  logic [NNW-1:0] nrn_base;
  logic [NNW:0]   nrn_count;
  logic [VW-1:0]  cfg_vth;
  logic [VW-1:0]  cfg_leak;
  logic [1:0]     cfg_reset_mode;
  logic [RW-1:0]  cfg_refrac;
  logic           sd_re;
  logic [NNW-1:0] sd_addr;
  logic [VW-1:0]  sd_vm;
  logic           spk_vld;
  logic [NNW-1:0] spk_addr;
  logic           spk_rdy;
  logic           busy;
  logic           done;
  logic           cfg_we;
  logic           cfg_re;
  logic [NNW-1:0] cfg_addr;
  logic [VW-1:0]  cfg_wdata;
  logic [VW-1:0]  cfg_rdata;

  soma_pipe #(.NNW(NNW), .VW(VW), .RW(RW), .FD(FD)) dut (
    .clk_soma       (clk_soma),
    .rst_n          (rst_n),
    .start          (start),
    .nrn_base       (nrn_base),
    .nrn_count      (nrn_count),
    .cfg_vth        (cfg_vth),
    .cfg_leak       (cfg_leak),
    .cfg_reset_mode (cfg_reset_mode),
    .cfg_refrac     (cfg_refrac),
    .sd_re          (sd_re),
    .sd_addr        (sd_addr),
    .sd_vm          (sd_vm),
    .spk_vld        (spk_vld),
    .spk_addr       (spk_addr),
    .spk_rdy        (spk_rdy),
    .busy           (busy),
    .done           (done),
    .cfg_we         (cfg_we),
    .cfg_re         (cfg_re),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata)
  );

  initial clk_soma = 1'b0;
  always #5 clk_soma = ~clk_soma;

  int n_tests = 0;
  int n_fail  = 0;
  int issue_addr_q[$];
  int issue_cyc_q[$];
  int spk_q[$];
  int spk_cyc_q[$];
  int done_cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_soma);
    #1;
  endtask

  task automatic host_write(input int a, input int d);
    cfg_addr  = a[NNW-1:0];
    cfg_wdata = d[VW-1:0];
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic host_read(input int a, output int d);
    cfg_addr = a[NNW-1:0];
    cfg_re   = 1'b1;
    tick();
    cfg_re   = 1'b0;
    d        = int'(cfg_rdata);
  endtask

  // Start at cycle 0, observe cycles 1.. until done; returns in the done cycle.
  task automatic sweep(input int base, input int cnt, input int rdy_from, input int max_cyc);
    issue_addr_q.delete();
    issue_cyc_q.delete();
    spk_q.delete();
    spk_cyc_q.delete();
    done_cyc  = -1;
    nrn_base  = base[NNW-1:0];
    nrn_count = cnt[NNW:0];
    spk_rdy   = (rdy_from <= 0);
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      spk_rdy = (c >= rdy_from);
      if (sd_re) begin
        issue_addr_q.push_back(int'(sd_addr));
        issue_cyc_q.push_back(c);
      end
      if (spk_vld && spk_rdy) begin
        spk_q.push_back(int'(spk_addr));
        spk_cyc_q.push_back(c);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    check("sweep_done_seen", int'(done_cyc >= 0), 1);
  endtask

  task automatic drain(input int max_cyc);
    spk_rdy = 1'b1;
    tick();
    for (int c = 0; c < max_cyc; c++) begin
      if (!spk_vld) break;
      spk_q.push_back(int'(spk_addr));
      tick();
    end
  endtask

  int rv;
  int n_early;

  initial begin
    rst_n = 1'b0; start = 1'b0; nrn_base = '0; nrn_count = '0;
    cfg_vth = '0; cfg_leak = '0; cfg_reset_mode = 2'b00; cfg_refrac = '0;
    sd_vm = '0; spk_rdy = 1'b0; cfg_we = 1'b0; cfg_re = 1'b0;
    cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk_soma);
    @(negedge clk_soma);
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_spk_vld", int'(spk_vld), 0);
    check("rst_sd_re", int'(sd_re), 0);
    check("rst_sd_addr", int'(sd_addr), 0);
    check("rst_spk_addr", int'(spk_addr), 0);
    check("rst_cfg_rdata", int'(cfg_rdata), 0);

    // Single neuron fires, subtract-threshold reset: 90+15=105 -> 5
    host_write(5, 90);
    cfg_vth = 100; cfg_leak = 3; sd_vm = 15; cfg_reset_mode = 2'b01; cfg_refrac = 3;
    sweep(5, 1, 0, 20);
    check("t1_issue_n", issue_addr_q.size(), 1);
    check("t1_issue_addr", issue_addr_q.size() > 0 ? issue_addr_q[0] : -1, 5);
    check("t1_issue_cyc", issue_cyc_q.size() > 0 ? issue_cyc_q[0] : -1, 1);
    check("t1_spk_addr", spk_q.size() > 0 ? spk_q[0] : -1, 5);
    check("t1_spk_cyc", spk_cyc_q.size() > 0 ? spk_cyc_q[0] : -1, 3);
    check("t1_done_cyc", done_cyc, 3);
    check("t1_busy_at_done", int'(busy), 1);
    drain(10);
    check("t1_busy_after", int'(busy), 0);
    host_read(5, rv);
    check("t1_vm", rv, 5);

    // Refractory: fire, two silent sweeps with vm held, fire again
    host_write(7, 0);
    cfg_vth = 100; cfg_leak = 3; sd_vm = 200; cfg_reset_mode = 2'b01; cfg_refrac = 2;
    for (int s = 1; s <= 4; s++) begin
      sweep(7, 1, 0, 20);
      check($sformatf("t2_spikes_s%0d", s), spk_q.size(), (s == 1 || s == 4) ? 1 : 0);
      drain(10);
      host_read(7, rv);
      check($sformatf("t2_vm_s%0d", s), rv, (s == 4) ? 200 : 100);
    end

    // Saturating sum, no-reset mode keeps the saturated value
    host_write(9, 1048566);
    cfg_vth = 1048575; sd_vm = 50; cfg_reset_mode = 2'b10; cfg_refrac = 0; cfg_leak = 3;
    sweep(9, 1, 0, 20);
    check("t3_spikes", spk_q.size(), 1);
    drain(10);
    host_read(9, rv);
    check("t3_vm", rv, 1048575);

    // Address wrap and leak: 4094:10+5-6=9, 4095:6-6 -> 0, 0:2+5-6=1
    host_write(4094, 10);
    host_write(4095, 1);
    host_write(0, 2);
    host_write(1, 0);
    cfg_vth = 100; cfg_leak = 6; sd_vm = 5; cfg_reset_mode = 2'b00; cfg_refrac = 0;
    sweep(4094, 4, 0, 30);
    check("t4_issue_n", issue_addr_q.size(), 4);
    check("t4_addr0", issue_addr_q.size() > 0 ? issue_addr_q[0] : -1, 4094);
    check("t4_addr1", issue_addr_q.size() > 1 ? issue_addr_q[1] : -1, 4095);
    check("t4_addr2", issue_addr_q.size() > 2 ? issue_addr_q[2] : -1, 0);
    check("t4_addr3", issue_addr_q.size() > 3 ? issue_addr_q[3] : -1, 1);
    check("t4_last_issue_cyc", issue_cyc_q.size() > 3 ? issue_cyc_q[3] : -1, 4);
    check("t4_done_cyc", done_cyc, 6);
    check("t4_spikes", spk_q.size(), 0);
    drain(10);
    host_read(4094, rv);
    check("t4_vm_4094", rv, 9);
    host_read(4095, rv);
    check("t4_vm_4095", rv, 0);
    host_read(0, rv);
    check("t4_vm_0", rv, 1);

    // Backpressure: 16 firing neurons, spk_rdy low for cycles 1..20
    for (int i = 0; i < 16; i++) host_write(100 + i, 0);
    cfg_vth = 100; cfg_leak = 0; sd_vm = 200; cfg_reset_mode = 2'b00; cfg_refrac = 0;
    sweep(100, 16, 21, 200);
    n_early = 0;
    foreach (issue_cyc_q[i]) if (issue_cyc_q[i] <= 20) n_early++;
    check("t5_issues_before_release", n_early, 4);
    check("t5_resume_cyc", issue_cyc_q.size() > 4 ? issue_cyc_q[4] : -1, 22);
    check("t5_issue_n", issue_addr_q.size(), 16);
    drain(40);
    check("t5_spk_total", spk_q.size(), 16);
    for (int i = 0; i < 16; i++)
      check($sformatf("t5_spk_order%0d", i), i < spk_q.size() ? spk_q[i] : -1, 100 + i);

    // Reset mid-sweep; host write while busy must be dropped
    host_write(300, 11);
    host_write(200, 50);
    host_write(201, 50);
    nrn_base = 100; nrn_count = 16; spk_rdy = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    cfg_addr = 300; cfg_wdata = 777; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("t6_busy_pre", int'(busy), 1);
    check("t6_vld_pre", int'(spk_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy_rst", int'(busy), 0);
    check("t6_vld_rst", int'(spk_vld), 0);
    check("t6_done_rst", int'(done), 0);
    check("t6_sd_re_rst", int'(sd_re), 0);
    @(negedge clk_soma);
    rst_n = 1'b1;
    tick();
    host_read(300, rv);
    check("t6_busy_write_dropped", rv, 11);
    cfg_vth = 1000; cfg_leak = 0; sd_vm = 10; cfg_reset_mode = 2'b00; cfg_refrac = 0;
    sweep(200, 2, 0, 30);
    check("t6_issue_n", issue_addr_q.size(), 2);
    check("t6_done_cyc", done_cyc, 4);
    check("t6_spikes", spk_q.size(), 0);
    drain(10);
    host_read(200, rv);
    check("t6_vm_200", rv, 60);

    // Empty sweep, and a start coincident with done is ignored
    sweep(50, 0, 0, 10);
    check("t7_done_cyc", done_cyc, 1);
    check("t7_issue_n", issue_addr_q.size(), 0);
    nrn_count = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t7_busy_after_done_start", int'(busy), 0);
    check("t7_sd_re_after", int'(sd_re), 0);
    tick();
    check("t7_busy_later", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
